check_ram_writer: RTL and testbench
===================================

CHECK_RAM_WRITER -- requirements
Module: check_ram_writer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 32, VA width; RAM_DATA_WIDTH 32, RAM word width; PAGE_SIZE 4096, page bytes; SET_WIDTH 5, set-index width minus one; OFFSET_WIDTH 4, entry-in-set index width.
REQ-002 SHALL define locally AW = SET_WIDTH+OFFSET_WIDTH+1, N = 2**OFFSET_WIDTH (entries per set), IGNORE_LSB = log2(PAGE_SIZE).
REQ-003 clk_i  in  1  clock; one clock, all state on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  in / out  1  request handshake.
REQ-006 req_va  in  ADDR_WIDTH  virtual address of the page to program.
REQ-007 req_inval  in  1  1 = invalidate the entry, 0 = write the entry.
REQ-008 req_master, req_wen, req_ren  in  1 each  entry attributes.
REQ-009 port0_addr, port1_addr  out  AW  RAM addresses: set field [AW-1:OFFSET_WIDTH], entry field [OFFSET_WIDTH-1:0].
REQ-010 port0_data, port1_data  in  RAM_DATA_WIDTH  RAM read data, valid one cycle after the address with ram_we low.
REQ-011 ram_we  out  1  RAM write enable; the write address is port0_addr.
REQ-012 ram_wdata  out  RAM_DATA_WIDTH  RAM write word.
REQ-013 busy  out  1  high when not IDLE; the lookup path SHALL ignore RAM outputs while busy.
REQ-014 resp_valid / resp_ready  out / in  1  response handshake.
REQ-015 resp_status  out  2  00 NEW, 01 UPDATED, 10 EVICTED, 11 NOT_FOUND.
REQ-016 resp_addr  out  AW  RAM address written or matched.

Function
REQ-017 RAM word format: [RAM_DATA_WIDTH-1:4] = req_va[ADDR_WIDTH-1:IGNORE_LSB], zero-extended; [3] master; [2] wen; [1] ren; [0] valid.
REQ-018 Set index = req_va[IGNORE_LSB +: SET_WIDTH+1], captured with all request fields on req_valid && req_ready.
REQ-019 FSM states: IDLE, SCAN, WRITE, RESP. req_ready = 1 only in IDLE.
REQ-020 IDLE -> SCAN on accept; scan pair counter k = 0.
REQ-021 SCAN, cycle k (0..N/2-1): port0_addr = {set, 2k}, port1_addr = {set, 2k+1}; ram_we = 0.
REQ-022 SCAN, cycle k >= 1: evaluate data of pair k-1; record the lowest-index tag match (valid && tag equal) and the lowest-index invalid entry. Port0 has priority over port1 within a pair.
REQ-023 SCAN lasts exactly N/2+1 cycles; the final cycle only evaluates. Then SCAN -> WRITE.
REQ-024 WRITE, non-invalidate: target = match, else first invalid, else victim pointer. Status is UPDATED, NEW or EVICTED respectively. ram_we = 1 for one cycle with the REQ-017 word, valid bit = 1.
REQ-025 WRITE, invalidate with a match: write an all-zero word to the match, status UPDATED. With no match: ram_we stays 0, status NOT_FOUND, resp_addr = {set, 0}.
REQ-026 Victim pointer: OFFSET_WIDTH bits, increments and wraps modulo N only on an EVICTED write.
REQ-027 WRITE -> RESP. In RESP, resp_valid = 1; resp_status and resp_addr are held stable until resp_ready. On resp_valid && resp_ready -> IDLE, the same cycle.
REQ-028 Latency from request accept to resp_valid is N/2+3 cycles (11 for N=16).
REQ-029 Port addresses SHALL be 0 in IDLE and RESP.

Reset
REQ-030 Reset SHALL force: state IDLE, k 0, victim pointer 0, resp_valid 0, ram_we 0, busy 0, req_ready 1, resp_status 00, resp_addr 0, captured fields 0.
REQ-031 Reset asserted mid-SCAN or mid-WRITE SHALL abort the operation immediately with no further ram_we pulses; the RAM keeps the words already written.

Structure
REQ-032 A shared RAB L2 package SHALL hold: the writer state enum, the status enum, and the RAM word bit positions (VALID 0, REN 1, WEN 2, MASTER 3, TAG_LSB 4), for use by both the check path and this writer.
REQ-033 No sub-module; the match and free-entry tracking SHALL be inline registers.

Verification (N=16, SET_WIDTH=5)
REQ-034 Empty RAM, write VA 0x0001_2000 -> NEW, resp_addr {set 0x12, 0}, wdata 0x0000_012F with master=1, wen=1, ren=1; resp_valid 11 cycles after accept.
REQ-035 Rewrite the same VA with wen=0 -> UPDATED, same resp_addr, bit2 = 0.
REQ-036 Fill all 16 entries of one set, then a 17th distinct VA -> EVICTED at entry 0; an 18th VA -> entry 1.
REQ-037 Invalidate an absent VA -> NOT_FOUND with no ram_we pulse. Invalidate a present VA -> word 0 written, UPDATED.
REQ-038 Hold resp_ready low for 5 cycles -> response stays stable and req_ready stays 0. Assert rst_ni low during SCAN cycle 4 -> IDLE at once, ram_we never pulses.

Source files
------------

// File: rtl/check_ram_writer_pkg.sv
// Shared definitions for the RAB L2 check path and the RAM writer.
// Holds the writer state encoding, the response status codes and the
// bit positions of the fields inside one L2 RAM word.
package check_ram_writer_pkg;

    // Writer FSM states.
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_SCAN  = 2'd1,
        W_WRITE = 2'd2,
        W_RESP  = 2'd3
    } writer_state_e;

    // Outcome reported on resp_status.
    typedef enum logic [1:0] {
        ST_NEW       = 2'b00,
        ST_UPDATED   = 2'b01,
        ST_EVICTED   = 2'b10,
        ST_NOT_FOUND = 2'b11
    } resp_status_e;

    // RAM word layout: [W-1:TAG_LSB] tag, then master/wen/ren/valid flags.
    localparam int RAM_VALID_BIT  = 0;
    localparam int RAM_REN_BIT    = 1;
    localparam int RAM_WEN_BIT    = 2;
    localparam int RAM_MASTER_BIT = 3;
    localparam int RAM_TAG_LSB    = 4;

    // Packs the four flag bits into their positions below the tag field.
    function automatic logic [RAM_TAG_LSB-1:0] attr_bits(
        input logic master,
        input logic wen,
        input logic ren,
        input logic valid
    );
        logic [RAM_TAG_LSB-1:0] a;
        a                 = '0;
        a[RAM_MASTER_BIT] = master;
        a[RAM_WEN_BIT]    = wen;
        a[RAM_REN_BIT]    = ren;
        a[RAM_VALID_BIT]  = valid;
        return a;
    endfunction

endpackage

// File: rtl/check_ram_writer.sv
// Programs / invalidates one entry of a set-associative L2 translation RAM.
// Latency: N/2+3 cycles from request accept to resp_valid (11 for N=16).
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_va, req_inval, req_master/wen/ren
//   port0_addr/port1_addr      dual RAM read addresses {set, entry}; port0 is also the write address
//   port0_data/port1_data      RAM read data, one cycle after the address
//   ram_we/ram_wdata           single-cycle RAM write
//   busy                       high whenever the writer owns the RAM ports
//   resp_valid/resp_ready      response handshake; resp_status, resp_addr
module check_ram_writer
    import check_ram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int PAGE_SIZE      = 4096,
    parameter int SET_WIDTH      = 5,
    parameter int OFFSET_WIDTH   = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,

    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [ADDR_WIDTH-1:0]                      req_va,
    input  logic                                       req_inval,
    input  logic                                       req_master,
    input  logic                                       req_wen,
    input  logic                                       req_ren,

    output logic [SET_WIDTH+OFFSET_WIDTH:0]            port0_addr,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]            port1_addr,
    input  logic [RAM_DATA_WIDTH-1:0]                  port0_data,
    input  logic [RAM_DATA_WIDTH-1:0]                  port1_data,
    output logic                                       ram_we,
    output logic [RAM_DATA_WIDTH-1:0]                  ram_wdata,

    output logic                                       busy,

    output logic                                       resp_valid,
    input  logic                                       resp_ready,
    output logic [1:0]                                 resp_status,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]            resp_addr
);

    localparam int AW         = SET_WIDTH + OFFSET_WIDTH + 1;
    localparam int N          = 2 ** OFFSET_WIDTH;
    localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
    localparam int TAGW       = ADDR_WIDTH - IGNORE_LSB;
    localparam int SW         = SET_WIDTH + 1;

    // k runs 0..N/2, which always fits in OFFSET_WIDTH bits.
    localparam logic [OFFSET_WIDTH-1:0] K_LAST = OFFSET_WIDTH'(N / 2);
    localparam logic [OFFSET_WIDTH-1:0] K_PEN  = OFFSET_WIDTH'(N / 2 - 1);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    writer_state_e             state;
    logic [OFFSET_WIDTH-1:0]   k;
    logic [OFFSET_WIDTH-1:0]   victim;

    logic [SW-1:0]             cap_set;
    logic [TAGW-1:0]           cap_tag;
    logic                      cap_inval;
    logic                      cap_master;
    logic                      cap_wen;
    logic                      cap_ren;

    // Lookup tracking across the scan.
    logic                      match_vld;
    logic [OFFSET_WIDTH-1:0]   match_idx;
    logic                      free_vld;
    logic [OFFSET_WIDTH-1:0]   free_idx;

    logic [1:0]                resp_status_q;

    // ------------------------------------------------------------------
    // Pair evaluation and write decision
    // ------------------------------------------------------------------
    logic [RAM_DATA_WIDTH-RAM_TAG_LSB-1:0] tag_ext;
    logic                      hit0, hit1, free0, free1;
    logic [OFFSET_WIDTH-1:0]   pair_idx0, pair_idx1;
    logic [OFFSET_WIDTH-1:0]   nxt_idx0, nxt_idx1;
    logic                      match_vld_n, free_vld_n;
    logic [OFFSET_WIDTH-1:0]   match_idx_n, free_idx_n;
    logic                      we_n;
    logic [RAM_DATA_WIDTH-1:0] wdata_n;
    logic [OFFSET_WIDTH-1:0]   tgt_n;
    resp_status_e              status_n;
    logic                      evict_n;

    always_comb begin
        tag_ext            = '0;
        tag_ext[TAGW-1:0]  = cap_tag;
    end

    assign hit0  = port0_data[RAM_VALID_BIT] &&
                   (port0_data[RAM_DATA_WIDTH-1:RAM_TAG_LSB] == tag_ext);
    assign hit1  = port1_data[RAM_VALID_BIT] &&
                   (port1_data[RAM_DATA_WIDTH-1:RAM_TAG_LSB] == tag_ext);
    assign free0 = !port0_data[RAM_VALID_BIT];
    assign free1 = !port1_data[RAM_VALID_BIT];

    // Data seen in cycle k belongs to the pair addressed in cycle k-1.
    always_comb begin
        pair_idx0 = OFFSET_WIDTH'(2 * (int'(k) - 1));
        pair_idx1 = OFFSET_WIDTH'(2 * (int'(k) - 1) + 1);
        nxt_idx0  = OFFSET_WIDTH'(2 * (int'(k) + 1));
        nxt_idx1  = OFFSET_WIDTH'(2 * (int'(k) + 1) + 1);
    end

    // Only the first hit / first free entry is kept; pairs arrive in
    // ascending order and port0 is checked before port1.
    always_comb begin
        match_vld_n = match_vld;
        match_idx_n = match_idx;
        free_vld_n  = free_vld;
        free_idx_n  = free_idx;
        if (state == W_SCAN && k != '0) begin
            if (!match_vld) begin
                if (hit0) begin
                    match_vld_n = 1'b1;
                    match_idx_n = pair_idx0;
                end else if (hit1) begin
                    match_vld_n = 1'b1;
                    match_idx_n = pair_idx1;
                end
            end
            if (!free_vld) begin
                if (free0) begin
                    free_vld_n = 1'b1;
                    free_idx_n = pair_idx0;
                end else if (free1) begin
                    free_vld_n = 1'b1;
                    free_idx_n = pair_idx1;
                end
            end
        end
    end

    // Decision uses the *_n values so the last pair is already included
    // when the WRITE-cycle registers are loaded.
    always_comb begin
        we_n     = 1'b1;
        wdata_n  = '0;
        tgt_n    = '0;
        status_n = ST_NEW;
        evict_n  = 1'b0;
        if (cap_inval) begin
            if (match_vld_n) begin
                tgt_n    = match_idx_n;
                status_n = ST_UPDATED;
            end else begin
                we_n     = 1'b0;
                status_n = ST_NOT_FOUND;
            end
        end else begin
            wdata_n[RAM_DATA_WIDTH-1:RAM_TAG_LSB] = tag_ext;
            wdata_n[RAM_TAG_LSB-1:0] = attr_bits(cap_master, cap_wen, cap_ren, 1'b1);
            if (match_vld_n) begin
                tgt_n    = match_idx_n;
                status_n = ST_UPDATED;
            end else if (free_vld_n) begin
                tgt_n    = free_idx_n;
                status_n = ST_NEW;
            end else begin
                tgt_n    = victim;
                status_n = ST_EVICTED;
                evict_n  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= W_IDLE;
            k             <= '0;
            victim        <= '0;
            cap_set       <= '0;
            cap_tag       <= '0;
            cap_inval     <= 1'b0;
            cap_master    <= 1'b0;
            cap_wen       <= 1'b0;
            cap_ren       <= 1'b0;
            match_vld     <= 1'b0;
            match_idx     <= '0;
            free_vld      <= 1'b0;
            free_idx      <= '0;
            port0_addr    <= '0;
            port1_addr    <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            busy          <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_status_q <= ST_NEW;
            resp_addr     <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= W_SCAN;
                        k          <= '0;
                        cap_set    <= req_va[IGNORE_LSB +: SW];
                        cap_tag    <= req_va[ADDR_WIDTH-1:IGNORE_LSB];
                        cap_inval  <= req_inval;
                        cap_master <= req_master;
                        cap_wen    <= req_wen;
                        cap_ren    <= req_ren;
                        match_vld  <= 1'b0;
                        free_vld   <= 1'b0;
                        port0_addr <= {req_va[IGNORE_LSB +: SW], OFFSET_WIDTH'(0)};
                        port1_addr <= {req_va[IGNORE_LSB +: SW], OFFSET_WIDTH'(1)};
                        busy       <= 1'b1;
                        req_ready  <= 1'b0;
                    end
                end

                W_SCAN: begin
                    match_vld <= match_vld_n;
                    match_idx <= match_idx_n;
                    free_vld  <= free_vld_n;
                    free_idx  <= free_idx_n;
                    if (k == K_LAST) begin
                        // Evaluation-only cycle done: load the write.
                        state         <= W_WRITE;
                        ram_we        <= we_n;
                        ram_wdata     <= wdata_n;
                        port0_addr    <= {cap_set, tgt_n};
                        port1_addr    <= '0;
                        resp_status_q <= status_n;
                        resp_addr     <= {cap_set, tgt_n};
                        if (evict_n) begin
                            victim <= victim + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                        if (k == K_PEN) begin
                            port0_addr <= '0;
                            port1_addr <= '0;
                        end else begin
                            port0_addr <= {cap_set, nxt_idx0};
                            port1_addr <= {cap_set, nxt_idx1};
                        end
                    end
                end

                W_WRITE: begin
                    state      <= W_RESP;
                    ram_we     <= 1'b0;
                    port0_addr <= '0;
                    port1_addr <= '0;
                    resp_valid <= 1'b1;
                end

                W_RESP: begin
                    if (resp_ready) begin
                        state      <= W_IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                        k          <= '0;
                    end
                end

                default: begin
                    state <= W_IDLE;
                end
            endcase
        end
    end

    assign resp_status = resp_status_q;

    // Page-offset bits and the stored flag bits are not needed for lookup.
    logic unused_bits;
    assign unused_bits = ^{req_va[IGNORE_LSB-1:0],
                           port0_data[RAM_TAG_LSB-1:RAM_VALID_BIT+1],
                           port1_data[RAM_TAG_LSB-1:RAM_VALID_BIT+1]};

endmodule

// File: tb/tb_check_ram_writer.sv
module tb_check_ram_writer;
    import check_ram_writer_pkg::*;

    localparam int AW = 10;
    localparam int N  = 16;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_va = '0;
    logic          req_inval = 1'b0;
    logic          req_master = 1'b0;
    logic          req_wen = 1'b0;
    logic          req_ren = 1'b0;
    logic [AW-1:0] port0_addr, port1_addr;
    logic [DW-1:0] port0_data, port1_data;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic          busy;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_status;
    logic [AW-1:0] resp_addr;

    always #5 clk_i = ~clk_i;

    check_ram_writer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_va     (req_va),
        .req_inval  (req_inval),
        .req_master (req_master),
        .req_wen    (req_wen),
        .req_ren    (req_ren),
        .port0_addr (port0_addr),
        .port1_addr (port1_addr),
        .port0_data (port0_data),
        .port1_data (port1_data),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_status(resp_status),
        .resp_addr  (resp_addr)
    );

    // Dual-port RAM with one-cycle read latency, written through port0.
    logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk_i) begin
        if (ram_we) ram[port0_addr] <= ram_wdata;
        port0_data <= ram[port0_addr];
        port1_data <= ram[port1_addr];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]    status;
        logic [AW-1:0] addr;
        bit            has_wr;
        logic [DW-1:0] wdata;
    } exp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    exp_t          sbq[$];
    wr_t           wq[$];
    logic [DW-1:0] ref_mem [0:63][0:N-1];
    int            victim = 0;

    // Linear search over the set: first valid tag match, else first invalid
    // slot, else the round-robin victim.
    task automatic model_req(input logic [31:0] va, input bit inval, input bit m,
                             input bit w, input bit r);
        int         set, mi, fi, tgt;
        logic [27:0] tag;
        exp_t       e;
        wr_t        wr;
        set = int'(va[17:12]);
        tag = {8'h0, va[31:12]};
        mi = -1;
        fi = -1;
        for (int i = 0; i < N; i++) begin
            if (mi < 0 && ref_mem[set][i][0] && ref_mem[set][i][31:4] == tag) mi = i;
            if (fi < 0 && !ref_mem[set][i][0]) fi = i;
        end
        e.has_wr = 1'b1;
        e.wdata  = '0;
        tgt      = 0;
        if (inval) begin
            if (mi >= 0) begin tgt = mi; e.status = 2'b01; end
            else begin e.status = 2'b11; e.has_wr = 1'b0; end
        end else begin
            e.wdata = {tag, m, w, r, 1'b1};
            if (mi >= 0)      begin tgt = mi; e.status = 2'b01; end
            else if (fi >= 0) begin tgt = fi; e.status = 2'b00; end
            else begin tgt = victim; e.status = 2'b10; victim = (victim + 1) % N; end
        end
        e.addr = AW'(set * N + tgt);
        if (e.has_wr) begin
            ref_mem[set][tgt] = e.wdata;
            wr.addr = e.addr;
            wr.data = e.wdata;
            wq.push_back(wr);
        end
        sbq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit            in_resp = 0;
    int            acc_cyc = 0;
    int            n_resp = 0;
    int            n_we = 0;
    logic [1:0]    hold_status;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] last_wdata = '0;

    always @(negedge clk_i) begin
        exp_t e;
        wr_t  w;
        if (!rst_ni) begin
            in_resp = 0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (ram_we) begin
                n_we++;
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", port0_addr, ram_wdata);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", port0_addr, w.addr);
                    check("wr_data", ram_wdata, w.data);
                    last_wdata = ram_wdata;
                end
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: status %0d addr 0x%0h, expected none", resp_status, resp_addr);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_status", resp_status, e.status);
                        check("resp_addr", resp_addr, e.addr);
                        check("latency", cyc - acc_cyc, 11);
                    end
                    hold_status = resp_status;
                    hold_addr   = resp_addr;
                end else begin
                    check("stable_status", resp_status, hold_status);
                    check("stable_addr", resp_addr, hold_addr);
                end
                check("resp_port_addrs", {port0_addr, port1_addr}, 0);
                check("resp_req_ready", req_ready, 0);
                check("resp_busy", busy, 1);
                if (resp_ready) begin
                    in_resp = 0;
                    n_resp++;
                end
            end
        end
    end

    // resp_ready: random unless forced low.
    bit rr_hold = 0;
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            resp_ready = rr_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_req(input logic [31:0] va, input bit inval, input bit m,
                             input bit w, input bit r);
        int budget;
        @(posedge clk_i);
        #1;
        req_valid = 1'b1; req_va = va; req_inval = inval;
        req_master = m; req_wen = w; req_ren = r;
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(posedge clk_i);
            #1;
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
        end
        @(posedge clk_i);
        #1;
        // Scramble inputs after accept: the DUT must use captured values.
        req_valid = 1'b0;
        req_va = $urandom; req_inval = $urandom_range(0, 1);
        req_master = $urandom_range(0, 1); req_wen = $urandom_range(0, 1); req_ren = $urandom_range(0, 1);
    endtask

    task automatic wait_resp(input int target);
        int budget;
        budget = 0;
        while (n_resp < target && budget < 200) begin
            @(posedge clk_i);
            budget++;
        end
        if (n_resp < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: responses %0d, expected %0d", n_resp, target);
        end
    endtask

    task automatic do_req(input logic [31:0] va, input bit inval, input bit m,
                          input bit w, input bit r);
        int target;
        model_req(va, inval, m, w, r);
        target = n_resp + 1;
        issue_req(va, inval, m, w, r);
        wait_resp(target);
    endtask

    initial begin
        int         we_snap, budget, target;
        logic [5:0] s;
        logic [31:0] va;

        for (int si = 0; si < 64; si++)
            for (int ei = 0; ei < N; ei++) ref_mem[si][ei] = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_port_addrs", {port0_addr, port1_addr}, 0);
        check("rst_resp_status", resp_status, 0);
        check("rst_resp_addr", resp_addr, 0);
        rst_ni = 1'b1;

        // First write into an empty set
        do_req(32'h0001_2000, 0, 1, 1, 1);
        check("d1_status", hold_status, 2'b00);
        check("d1_addr", hold_addr, 10'h120);
        check("d1_wdata", last_wdata, 32'h0000_012F);

        // Rewrite with wen cleared
        do_req(32'h0001_2000, 0, 1, 0, 1);
        check("d2_status", hold_status, 2'b01);
        check("d2_addr", hold_addr, 10'h120);
        check("d2_wdata", last_wdata, 32'h0000_012B);

        // Fill the remaining 15 entries, then evict twice
        for (int i = 1; i < 16; i++) do_req((i << 18) | 32'h0001_2000, 0, 0, 1, 1);
        check("fill_last_addr", hold_addr, 10'h12F);
        do_req((16 << 18) | 32'h0001_2000, 0, 1, 1, 0);
        check("evict0_status", hold_status, 2'b10);
        check("evict0_addr", hold_addr, 10'h120);
        do_req((17 << 18) | 32'h0001_2000, 0, 1, 0, 0);
        check("evict1_status", hold_status, 2'b10);
        check("evict1_addr", hold_addr, 10'h121);

        // Invalidate absent then present
        we_snap = n_we;
        do_req((40 << 18) | 32'h0001_2000, 1, 0, 0, 0);
        check("inv_absent_status", hold_status, 2'b11);
        check("inv_absent_addr", hold_addr, 10'h120);
        check("inv_absent_no_we", n_we, we_snap);
        do_req((5 << 18) | 32'h0001_2000, 1, 0, 0, 0);
        check("inv_present_status", hold_status, 2'b01);
        check("inv_present_addr", hold_addr, 10'h125);
        check("inv_present_wdata", last_wdata, 0);

        // Response stall: resp_ready low for 5 cycles
        rr_hold = 1;
        @(posedge clk_i);
        #1;
        model_req(32'h0000_5123, 0, 0, 1, 0);
        target = n_resp + 1;
        issue_req(32'h0000_5123, 0, 0, 1, 0);
        budget = 0;
        while (!resp_valid && budget < 50) begin
            @(posedge clk_i);
            #1;
            budget++;
        end
        check("stall_resp_valid", resp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_req_ready", req_ready, 0);
            check("stall_valid_held", resp_valid, 1);
        end
        rr_hold = 0;
        wait_resp(target);

        // Reset during SCAN cycle 4
        we_snap = n_we;
        issue_req(32'h0003_2000, 0, 1, 1, 1);
        // issue_req returns #1 after the accept edge: SCAN k=0
        repeat (4) @(posedge clk_i);
        #1;
        check("scan_busy", busy, 1);
        rst_ni = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_ram_we", ram_we, 0);
        check("abort_port0", port0_addr, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        victim = 0;
        repeat (20) @(posedge clk_i);
        check("abort_no_we", n_we, we_snap);
        check("abort_no_resp", resp_valid, 0);

        // Random traffic over two sets
        for (int i = 0; i < 60; i++) begin
            s  = ($urandom_range(0, 1) != 0) ? 6'h12 : 6'h05;
            va = (32'($urandom_range(0, 19)) << 18) | (32'(s) << 12) | 32'($urandom_range(0, 4095));
            do_req(va, $urandom_range(0, 9) < 3, $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Final RAM contents of both exercised sets
        repeat (3) @(posedge clk_i);
        for (int e = 0; e < N; e++) begin
            check("ram_set12", ram[10'h120 + e], ref_mem[6'h12][e]);
            check("ram_set05", ram[10'h050 + e], ref_mem[6'h05][e]);
        end
        check("sb_empty", sbq.size(), 0);
        check("wq_empty", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
